// File: rtl/pixel_framebuffer_pkg.sv
// Shared colour constants, VGA 640x480@60 timing and clear-FSM state type.
package pixel_framebuffer_pkg;

    // {R,G,B} colour constants, also used by the painter
    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] BLUE  = 3'b001;
    localparam logic [2:0] WHITE = 3'b111;

    // Horizontal timing in 25 MHz pixel clocks
    localparam int VGA_H_VIS  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;

    // Vertical timing in lines
    localparam int VGA_V_VIS  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_SWEEP = 1'b1
    } clr_state_t;

endpackage

// File: rtl/pixel_framebuffer_timing.sv
// VGA scan generator: 25 MHz pixel enable, h/v counters, raw syncs,
// visible flag, frame tick and the logical (4x4-block) scan coordinates.
module vga_timing
    import pixel_framebuffer_pkg::*;
#(
    parameter int H_VIS  = VGA_H_VIS,
    parameter int H_FP   = VGA_H_FP,
    parameter int H_SYNC = VGA_H_SYNC,
    parameter int H_BP   = VGA_H_BP,
    parameter int V_VIS  = VGA_V_VIS,
    parameter int V_FP   = VGA_V_FP,
    parameter int V_SYNC = VGA_V_SYNC,
    parameter int V_BP   = VGA_V_BP
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    output logic       hs_raw,
    output logic       vs_raw,
    output logic       visible,
    output logic       frame_tick,
    output logic [7:0] scan_x,
    output logic [7:0] scan_y
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    logic       pix_en;
    logic [9:0] hcount;
    logic [9:0] vcount;

    // Pixel enable toggles every cycle; counters step on enabled cycles,
    // and the tick fires on the step into the first vertical-blank line.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pix_en     <= 1'b0;
            hcount     <= '0;
            vcount     <= '0;
            frame_tick <= 1'b0;
        end else begin
            pix_en     <= ~pix_en;
            frame_tick <= pix_en && (hcount == 10'(H_TOT - 1)) && (vcount == 10'(V_VIS - 1));
            if (pix_en) begin
                if (hcount == 10'(H_TOT - 1)) begin
                    hcount <= '0;
                    vcount <= (vcount == 10'(V_TOT - 1)) ? '0 : vcount + 10'd1;
                end else begin
                    hcount <= hcount + 10'd1;
                end
            end
        end
    end

    // Decode raw (unaligned) sync/blank from the counters
    always_comb begin
        hs_raw  = !((hcount >= 10'(H_VIS + H_FP)) && (hcount < 10'(H_VIS + H_FP + H_SYNC)));
        vs_raw  = !((vcount >= 10'(V_VIS + V_FP)) && (vcount < 10'(V_VIS + V_FP + V_SYNC)));
        visible = (hcount < 10'(H_VIS)) && (vcount < 10'(V_VIS));
        scan_x  = hcount[9:2];
        scan_y  = vcount[9:2];
    end

endmodule

// File: rtl/pixel_framebuffer.sv
// Pixel frame buffer: painter write port, hardware clear sweep, and a
// registered VGA scan-out of the buffer with 4x4 pixel replication.
module pixel_framebuffer
    import pixel_framebuffer_pkg::*;
#(
    parameter int         WIDTH     = 160,
    parameter int         HEIGHT    = 120,
    parameter logic [2:0] BG_COLOUR = BLACK,
    parameter int         ADDR_W    = 15,
    parameter int         H_VIS     = VGA_H_VIS,
    parameter int         H_FP      = VGA_H_FP,
    parameter int         H_SYNC    = VGA_H_SYNC,
    parameter int         H_BP      = VGA_H_BP,
    parameter int         V_VIS     = VGA_V_VIS,
    parameter int         V_FP      = VGA_V_FP,
    parameter int         V_SYNC    = VGA_V_SYNC,
    parameter int         V_BP      = VGA_V_BP
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       plot,
    input  logic [8:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    input  logic       clear,
    output logic       clear_busy,
    output logic       frame_tick,
    output logic [2:0] vga_colour,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n
);

    localparam int              NPIX = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);

    // Row-major address scaling by the constant WIDTH as a shift-add tree
    function automatic logic [ADDR_W-1:0] times_width(input logic [ADDR_W-1:0] v);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            if (((WIDTH >> i) & 1) != 0) acc = acc + (v << i);
        end
        return acc;
    endfunction

    logic       hs_raw, vs_raw, visible;
    logic [7:0] scan_x, scan_y;

    vga_timing #(
        .H_VIS (H_VIS),  .H_FP (H_FP),  .H_SYNC (H_SYNC),  .H_BP (H_BP),
        .V_VIS (V_VIS),  .V_FP (V_FP),  .V_SYNC (V_SYNC),  .V_BP (V_BP)
    ) u_timing (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .hs_raw     (hs_raw),
        .vs_raw     (vs_raw),
        .visible    (visible),
        .frame_tick (frame_tick),
        .scan_x     (scan_x),
        .scan_y     (scan_y)
    );

    logic              in_range;
    logic [ADDR_W-1:0] plot_addr;
    logic [ADDR_W-1:0] raddr;

    assign in_range  = (int'(x) < WIDTH) && (int'(y) < HEIGHT);
    assign plot_addr = times_width(ADDR_W'(y)) + ADDR_W'(x);
    assign raddr     = times_width(ADDR_W'(scan_y)) + ADDR_W'(scan_x);

    clr_state_t        state, state_nx;
    logic [ADDR_W-1:0] caddr, caddr_nx;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [2:0]        wdata;

    // Clear FSM state and sweep address; reset aborts a sweep in progress
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= CLR_IDLE;
            caddr <= '0;
        end else begin
            state <= state_nx;
            caddr <= caddr_nx;
        end
    end

    // Next state and write-port mux: painter writes only while idle
    always_comb begin
        state_nx = state;
        caddr_nx = caddr;
        we       = 1'b0;
        waddr    = plot_addr;
        wdata    = colour;
        case (state)
            CLR_IDLE: begin
                if (plot && in_range) we = 1'b1;
                if (clear) begin
                    state_nx = CLR_SWEEP;
                    caddr_nx = '0;
                end
            end
            CLR_SWEEP: begin
                we       = 1'b1;
                waddr    = caddr;
                wdata    = BG_COLOUR;
                caddr_nx = caddr + ADDR_W'(1);
                if (caddr == LAST) state_nx = CLR_IDLE;
            end
            default: state_nx = CLR_IDLE;
        endcase
    end

    assign clear_busy = (state == CLR_SWEEP);

    logic [2:0] mem [0:NPIX-1];

    // Frame buffer write port (contents intentionally not reset)
    always_ff @(posedge CLOCK_50) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read plus sync/blank delayed by the same one cycle
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            vga_colour  <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
        end else begin
            vga_colour  <= visible ? mem[raddr] : 3'b000;
            vga_hs      <= hs_raw;
            vga_vs      <= vs_raw;
            vga_blank_n <= visible;
        end
    end

endmodule
